// File: rtl/lot_lane_counter_if.sv
// ---------------------------------------------------------------------------
// lot_lane_counter_if
// Signal bundle between the parking-lot lane sensors / display side and the
// occupancy tracker.
//   a, b     : per-lane outer/inner sensor levels, 1 = blocked
//   clr_err  : synchronous clear of all sticky sequence-error flags
//   enter    : per-lane one-cycle pulse, completed entry
//   exit     : per-lane one-cycle pulse, completed exit
//   seq_err  : per-lane sticky illegal-sequence flag
//   count    : current lot occupancy
//   full     : count == CAPACITY
//   empty    : count == 0
//   reject   : one-cycle pulse, net event dropped by saturation
// Modports: master = sensor/display side, slave = tracker.
// ---------------------------------------------------------------------------
interface lot_lane_counter_if #(
  parameter int LANES = 2,
  parameter int CNT_W = 4
);
  logic [LANES-1:0] a;
  logic [LANES-1:0] b;
  logic             clr_err;
  logic [LANES-1:0] enter;
  logic [LANES-1:0] exit;
  logic [LANES-1:0] seq_err;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             reject;

  modport master (
    output a, b, clr_err,
    input  enter, exit, seq_err, count, full, empty, reject
  );

  modport slave (
    input  a, b, clr_err,
    output enter, exit, seq_err, count, full, empty, reject
  );
endinterface

// File: rtl/lot_lane_counter.sv
// ---------------------------------------------------------------------------
// lot_lane_counter
// Multi-lane parking-lot occupancy tracker. Every lane has an outer (a) and
// inner (b) sensor and its own direction FSM that only accepts a complete,
// ordered pass through both sensors. Completed entries/exits are registered
// as one-cycle pulses and summed into a shared saturating occupancy count.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-high reset
//   bus    : lot_lane_counter_if.slave (sensor inputs, clr_err, pulses,
//            seq_err, count, full, empty, reject)
// ---------------------------------------------------------------------------
module lot_lane_counter #(
  parameter int LANES    = 2,
  parameter int CAPACITY = 15,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  lot_lane_counter_if.slave   bus
);

  // Two guard bits so count + net never wraps before saturation.
  localparam int SUM_W = CNT_W + 2;
  localparam logic signed [SUM_W-1:0] CAP_S  = SUM_W'(CAPACITY);
  localparam logic signed [SUM_W-1:0] ONE_S  = SUM_W'(1);
  localparam logic signed [SUM_W-1:0] ZERO_S = '0;
  localparam logic        [CNT_W-1:0] CAP_U  = CNT_W'(CAPACITY);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    E1   = 3'd1,
    E2   = 3'd2,
    E3   = 3'd3,
    X1   = 3'd4,
    X2   = 3'd5,
    X3   = 3'd6,
    BAD  = 3'd7
  } state_t;

  state_t r_state [LANES];
  state_t w_state_nxt [LANES];

  logic [LANES-1:0] w_enter_nxt;
  logic [LANES-1:0] w_exit_nxt;
  logic [LANES-1:0] w_bad_set;

  logic [LANES-1:0] r_enter;
  logic [LANES-1:0] r_exit;
  logic [LANES-1:0] r_seq_err;
  logic [CNT_W-1:0] r_count;
  logic             r_reject;

  logic signed [SUM_W-1:0] w_net;
  logic signed [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0]        w_count_nxt;
  logic                    w_reject_nxt;

  // Clamp the widened sum into 0..CAPACITY; the MSB of the result flags
  // that clamping happened.
  function automatic logic [CNT_W:0] sat_count(input logic signed [SUM_W-1:0] sum);
    logic [CNT_W:0] res;
    if (sum > CAP_S) begin
      res = {1'b1, CAP_U};
    end else if (sum < ZERO_S) begin
      res = {1'b1, {CNT_W{1'b0}}};
    end else begin
      res = {1'b0, sum[CNT_W-1:0]};
    end
    return res;
  endfunction

  // Lane FSM next-state: input code is {a,b}. The exit path mirrors the
  // entry path with a and b swapped.
  always_comb begin
    w_enter_nxt = '0;
    w_exit_nxt  = '0;
    w_bad_set   = '0;
    for (int i = 0; i < LANES; i++) begin
      logic [1:0] code;
      code = {bus.a[i], bus.b[i]};
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        IDLE: case (code)
          2'b10:   w_state_nxt[i] = E1;
          2'b01:   w_state_nxt[i] = X1;
          2'b11:   w_state_nxt[i] = BAD;
          default: w_state_nxt[i] = IDLE;
        endcase
        E1: case (code)
          2'b11:   w_state_nxt[i] = E2;
          2'b00:   w_state_nxt[i] = IDLE;
          2'b01:   w_state_nxt[i] = BAD;
          default: w_state_nxt[i] = E1;
        endcase
        E2: case (code)
          2'b01:   w_state_nxt[i] = E3;
          2'b10:   w_state_nxt[i] = E1;
          2'b00:   w_state_nxt[i] = BAD;
          default: w_state_nxt[i] = E2;
        endcase
        E3: case (code)
          2'b00: begin
            w_state_nxt[i] = IDLE;
            w_enter_nxt[i] = 1'b1;
          end
          2'b11:   w_state_nxt[i] = E2;
          2'b10:   w_state_nxt[i] = BAD;
          default: w_state_nxt[i] = E3;
        endcase
        X1: case (code)
          2'b11:   w_state_nxt[i] = X2;
          2'b00:   w_state_nxt[i] = IDLE;
          2'b10:   w_state_nxt[i] = BAD;
          default: w_state_nxt[i] = X1;
        endcase
        X2: case (code)
          2'b10:   w_state_nxt[i] = X3;
          2'b01:   w_state_nxt[i] = X1;
          2'b00:   w_state_nxt[i] = BAD;
          default: w_state_nxt[i] = X2;
        endcase
        X3: case (code)
          2'b00: begin
            w_state_nxt[i] = IDLE;
            w_exit_nxt[i]  = 1'b1;
          end
          2'b11:   w_state_nxt[i] = X2;
          2'b01:   w_state_nxt[i] = BAD;
          default: w_state_nxt[i] = X3;
        endcase
        default: begin
          if (code == 2'b00) begin
            w_state_nxt[i] = IDLE;
          end
        end
      endcase
      // Only the transition into BAD sets the flag, so clr_err can clear a
      // lane that is still parked in BAD.
      w_bad_set[i] = (r_state[i] != BAD) && (w_state_nxt[i] == BAD);
    end
  end

  // Net occupancy change recognised on this edge, then saturated.
  always_comb begin
    logic [CNT_W:0] sat;
    w_net = ZERO_S;
    for (int i = 0; i < LANES; i++) begin
      if (w_enter_nxt[i]) w_net = w_net + ONE_S;
      if (w_exit_nxt[i])  w_net = w_net - ONE_S;
    end
    w_sum        = $signed({2'b00, r_count}) + w_net;
    sat          = sat_count(w_sum);
    w_count_nxt  = sat[CNT_W-1:0];
    w_reject_nxt = sat[CNT_W];
  end

  // ---- stage boundary: lane states, pulses, flags and count registered ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        r_state[i] <= IDLE;
      end
      r_enter   <= '0;
      r_exit    <= '0;
      r_seq_err <= '0;
      r_count   <= '0;
      r_reject  <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        r_state[i] <= w_state_nxt[i];
      end
      r_enter   <= w_enter_nxt;
      r_exit    <= w_exit_nxt;
      // A lane entering BAD wins over a simultaneous clear.
      r_seq_err <= (bus.clr_err ? '0 : r_seq_err) | w_bad_set;
      r_count   <= w_count_nxt;
      r_reject  <= w_reject_nxt;
    end
  end

  assign bus.enter   = r_enter;
  assign bus.exit    = r_exit;
  assign bus.seq_err = r_seq_err;
  assign bus.count   = r_count;
  assign bus.reject  = r_reject;
  assign bus.full    = (r_count == CAP_U);
  assign bus.empty   = (r_count == '0);

endmodule

// File: tb/tb_lot_lane_counter.sv
module tb_lot_lane_counter;
  localparam int LANES = 2;
  localparam int CNT_W = 4;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  lot_lane_counter_if #(.LANES(LANES), .CNT_W(CNT_W)) bus ();

  lot_lane_counter #(.LANES(LANES), .CAPACITY(15), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive lane codes, let one edge sample them, return #1 after the edge.
  task automatic tick(input logic [1:0] av, input logic [1:0] bv);
    bus.a = av;
    bus.b = bv;
    @(posedge clk);
    #1;
  endtask

  // Full pass on selected lanes: entry lanes 10,11,01,00; exit lanes 01,11,10,00.
  task automatic pass(input logic [1:0] en, input logic [1:0] ex);
    logic [1:0] ent_a [4];
    logic [1:0] ent_b [4];
    logic [1:0] av;
    logic [1:0] bv;
    ent_a = '{2'b10, 2'b11, 2'b01, 2'b00};
    for (int k = 0; k < 4; k++) begin
      av = '0;
      bv = '0;
      for (int l = 0; l < LANES; l++) begin
        if (en[l]) begin
          av[l] = ent_a[k][1];
          bv[l] = ent_a[k][0];
        end else if (ex[l]) begin
          av[l] = ent_a[k][0];
          bv[l] = ent_a[k][1];
        end
      end
      tick(av, bv);
    end
    ent_b = ent_a;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.a = '0;
    bus.b = '0;
    bus.clr_err = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count",   32'(bus.count),   32'd0);
    check("rst_empty",   32'(bus.empty),   32'd1);
    check("rst_full",    32'(bus.full),    32'd0);
    check("rst_enter",   32'(bus.enter),   32'd0);
    check("rst_exit",    32'(bus.exit),    32'd0);
    check("rst_seq_err", 32'(bus.seq_err), 32'd0);
    check("rst_reject",  32'(bus.reject),  32'd0);
    reset = 1'b0;

    // 1: lane0 entry
    tick(2'b00, 2'b00);
    tick(2'b01, 2'b00);
    tick(2'b01, 2'b01);
    tick(2'b00, 2'b01);
    check("t1_pre_enter", 32'(bus.enter), 32'd0);
    tick(2'b00, 2'b00);
    check("t1_enter", 32'(bus.enter), 32'd1);
    check("t1_count", 32'(bus.count), 32'd1);
    check("t1_empty", 32'(bus.empty), 32'd0);
    tick(2'b00, 2'b00);
    check("t1_enter_off", 32'(bus.enter), 32'd0);
    check("t1_count_hold", 32'(bus.count), 32'd1);

    // bring count to 3 with a dual-lane entry
    pass(2'b11, 2'b00);
    check("dual_enter", 32'(bus.enter), 32'd3);
    check("dual_count", 32'(bus.count), 32'd3);

    // 2: lane1 exit 00,01,11,10,00
    tick(2'b00, 2'b00);
    tick(2'b00, 2'b10);
    tick(2'b10, 2'b10);
    tick(2'b10, 2'b00);
    tick(2'b00, 2'b00);
    check("t2_exit", 32'(bus.exit), 32'd2);
    check("t2_count", 32'(bus.count), 32'd2);
    tick(2'b00, 2'b00);
    check("t2_exit_off", 32'(bus.exit), 32'd0);

    // 3: lane0 backs out 10,11,10,00
    tick(2'b01, 2'b00);
    tick(2'b01, 2'b01);
    tick(2'b01, 2'b00);
    tick(2'b00, 2'b00);
    check("t3_enter", 32'(bus.enter), 32'd0);
    check("t3_seq_err", 32'(bus.seq_err), 32'd0);
    tick(2'b00, 2'b00);
    check("t3_count", 32'(bus.count), 32'd2);

    // 4: lane0 illegal 00,11,00 then clear
    tick(2'b00, 2'b00);
    tick(2'b01, 2'b01);
    check("t4_seq_err_set", 32'(bus.seq_err), 32'd1);
    tick(2'b00, 2'b00);
    tick(2'b00, 2'b00);
    check("t4_seq_err_hold", 32'(bus.seq_err), 32'd1);
    check("t4_count", 32'(bus.count), 32'd2);
    bus.clr_err = 1'b1;
    tick(2'b00, 2'b00);
    bus.clr_err = 1'b0;
    check("t4_seq_err_clr", 32'(bus.seq_err), 32'd0);
    // lane1 goes BAD on the same edge as clr_err: set wins
    bus.clr_err = 1'b1;
    tick(2'b10, 2'b10);
    bus.clr_err = 1'b0;
    check("t4_set_wins", 32'(bus.seq_err), 32'd2);
    tick(2'b00, 2'b00);
    bus.clr_err = 1'b1;
    tick(2'b00, 2'b00);
    bus.clr_err = 1'b0;
    check("t4_clr2", 32'(bus.seq_err), 32'd0);
    check("t4_count2", 32'(bus.count), 32'd2);

    // 5: fill to 15 (2 + 6*2 + 1)
    for (int n = 0; n < 6; n++) pass(2'b11, 2'b00);
    pass(2'b01, 2'b00);
    check("t5_count15", 32'(bus.count), 32'd15);
    check("t5_full", 32'(bus.full), 32'd1);
    check("t5_no_reject", 32'(bus.reject), 32'd0);
    pass(2'b01, 2'b00);
    check("t5_sat_enter", 32'(bus.enter), 32'd1);
    check("t5_sat_reject", 32'(bus.reject), 32'd1);
    check("t5_sat_count", 32'(bus.count), 32'd15);
    check("t5_sat_full", 32'(bus.full), 32'd1);
    tick(2'b00, 2'b00);
    check("t5_reject_off", 32'(bus.reject), 32'd0);
    pass(2'b01, 2'b10);
    check("t5_cancel_enter", 32'(bus.enter), 32'd1);
    check("t5_cancel_exit", 32'(bus.exit), 32'd2);
    check("t5_cancel_count", 32'(bus.count), 32'd15);
    check("t5_cancel_reject", 32'(bus.reject), 32'd0);

    // 6: drain to 0 (15 = 7*2 + 1), then double exit underflows
    for (int n = 0; n < 7; n++) pass(2'b00, 2'b11);
    pass(2'b00, 2'b01);
    check("t6_count0", 32'(bus.count), 32'd0);
    check("t6_empty", 32'(bus.empty), 32'd1);
    pass(2'b00, 2'b11);
    check("t6_under_exit", 32'(bus.exit), 32'd3);
    check("t6_under_reject", 32'(bus.reject), 32'd1);
    check("t6_under_count", 32'(bus.count), 32'd0);
    tick(2'b00, 2'b00);
    // reset while lane0 is in E2
    tick(2'b01, 2'b00);
    tick(2'b01, 2'b01);
    reset = 1'b1;
    #2;
    check("t6_async_count", 32'(bus.count), 32'd0);
    check("t6_async_empty", 32'(bus.empty), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(2'b00, 2'b01);
    tick(2'b00, 2'b00);
    check("t6_no_enter", 32'(bus.enter), 32'd0);
    check("t6_no_exit", 32'(bus.exit), 32'd0);
    tick(2'b00, 2'b00);
    check("t6_final_count", 32'(bus.count), 32'd0);
    check("t6_final_err", 32'(bus.seq_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
